ssl_seq: RTL

- Frame sequencer for the ssl sound-source-localisation correlator (4×1-bit mic inputs, delay indices dIdA/dIdB/dIdC).
- Generates the correlator's sample strobe from a programmable divider and counts NDATA samples per frame.
- After a settle delay, latches the three delay indices into a result register with a valid/ready handshake.
- Sits between ssl and the downstream direction-of-arrival consumer.

---
 rtl/ssl_pkg.sv | 29 ++
 rtl/ssl_tick_div.sv | 46 ++++
 rtl/ssl_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ssl_pkg.sv
// ssl_pkg: shared types and constants for the ssl frame sequencer.
//   - state_e : sequencer states (IDLE, CAPT, SETTLE)
//   - NDATA_DEF : default samples per correlation frame
//   - id_width() : delay-index width derived from NDATA
//   - res_t : one latched result {a, b, c} at the default NDATA
package ssl_pkg;

    localparam int NDATA_DEF = 128;

    // Width needed to hold a delay index 0..ndata-1; never narrower than 1 bit.
    function automatic int id_width(input int ndata);
        return (ndata > 1) ? $clog2(ndata) : 1;
    endfunction

    localparam int ID_W_DEF = id_width(NDATA_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CAPT   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    typedef struct packed {
        logic [ID_W_DEF-1:0] a;
        logic [ID_W_DEF-1:0] b;
        logic [ID_W_DEF-1:0] c;
    } res_t;

endpackage

// File: rtl/ssl_tick_div.sv
// ssl_tick_div: programmable tick divider.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : reload the period and zero the count (takes effect next cycle)
//   period     : period in cycles; 0 is treated as 1
//   en         : count enable
//   tick       : one-cycle strobe when the count reaches period-1 while enabled
module ssl_tick_div #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         restart,
    input  logic [W-1:0] period,
    input  logic         en,
    output logic         tick
);

    logic [W-1:0] period_q, period_d;
    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == period_q - W'(1));

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
        period_d = period_q;
        cnt_d    = cnt_q;
        if (restart) begin
            period_d = (period == '0) ? W'(1) : period;
            cnt_d    = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= W'(1);
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ssl_seq.sv
// ssl_seq: frame sequencer for the ssl sound-source-localisation correlator.
//   clk, erst          : clock, asynchronous active-low reset
//   run                : capture frames continuously while high
//   div_val            : sample period in clk cycles (0 treated as 1), taken on frame start
//   smp_en             : one-cycle sample strobe to ssl
//   frm_start          : pulse on the first CAPT cycle of each frame
//   capt_act           : high while in CAPT
//   dId{A,B,C}_in      : delay indices from ssl
//   res_{a,b,c}        : latched delay indices, with res_valid / res_ready handshake
//   ovr, clr_ovr       : sticky overrun flag (a result overwritten before it was taken)
// Optional: define SSL_SEQ_FRMCNT_EN to add frm_cnt[7:0], a frame counter latched
// together with res_*.
module ssl_seq
    import ssl_pkg::*;
#(
    parameter int NDATA   = NDATA_DEF,
    parameter int DIV_W   = 16,
    parameter int RES_LAT = 2,
    localparam int ID_W   = id_width(NDATA)
) (
    input  logic             clk,
    input  logic             erst,
    input  logic             run,
    input  logic [DIV_W-1:0] div_val,
    output logic             smp_en,
    output logic             frm_start,
    output logic             capt_act,
    input  logic [ID_W-1:0]  dIdA_in,
    input  logic [ID_W-1:0]  dIdB_in,
    input  logic [ID_W-1:0]  dIdC_in,
    output logic [ID_W-1:0]  res_a,
    output logic [ID_W-1:0]  res_b,
    output logic [ID_W-1:0]  res_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             ovr,
`ifdef SSL_SEQ_FRMCNT_EN
    output logic [7:0]       frm_cnt,
`endif
    input  logic             clr_ovr
);

    localparam int SET_W = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

    typedef struct packed {
        logic [ID_W-1:0] a;
        logic [ID_W-1:0] b;
        logic [ID_W-1:0] c;
    } idx_set_t;

    state_e          state_q, state_d;
    logic [ID_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic            frm_start_q, frm_start_d;
    logic            res_valid_q, res_valid_d;
    logic            ovr_q, ovr_d;
    idx_set_t        res_q, res_d;
    logic            restart;
    logic            latch;
    logic            tick;

    // The divider only runs while capturing; dropping run gates the strobe at once.
    ssl_tick_div #(.W(DIV_W)) u_tick_div (
        .clk     (clk),
        .rst_n   (erst),
        .restart (restart),
        .period  (div_val),
        .en      ((state_q == CAPT) && run),
        .tick    (tick)
    );

    assign smp_en = tick;

    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        set_cnt_d = set_cnt_q;
        restart   = 1'b0;
        latch     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d   = CAPT;
                    restart   = 1'b1;
                    smp_cnt_d = '0;
                end
            end
            CAPT: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (smp_en) begin
                    smp_cnt_d = smp_cnt_q + ID_W'(1);
                    if (smp_cnt_q == ID_W'(NDATA - 1)) begin
                        state_d   = SETTLE;
                        set_cnt_d = '0;
                    end
                end
            end
            SETTLE: begin
                // run is ignored until the last settle cycle: a started frame always completes.
                if (set_cnt_q == SET_W'(RES_LAT - 1)) begin
                    latch     = 1'b1;
                    set_cnt_d = '0;
                    if (run) begin
                        state_d   = CAPT;
                        restart   = 1'b1;
                        smp_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frm_start_d = (state_d == CAPT) && (state_q != CAPT);
        res_d       = res_q;
        res_valid_d = res_valid_q;
        ovr_d       = ovr_q;
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end
        // A latch always leaves a valid result; it is an overrun only if the old one
        // was still pending and not taken this cycle. Set beats clear.
        if (latch) begin
            res_d       = '{a: dIdA_in, b: dIdB_in, c: dIdC_in};
            res_valid_d = 1'b1;
            if (res_valid_q && !res_ready) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge erst) begin
        if (!erst) begin
            state_q     <= IDLE;
            smp_cnt_q   <= '0;
            set_cnt_q   <= '0;
            frm_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
            // NOTE: the result register is reset too; it is small and its outputs must read 0 in reset.
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            set_cnt_q   <= set_cnt_d;
            frm_start_q <= frm_start_d;
            res_valid_q <= res_valid_d;
            ovr_q       <= ovr_d;
            res_q       <= res_d;
        end
    end

`ifdef SSL_SEQ_FRMCNT_EN
    logic [7:0] frm_cnt_q, frm_cnt_d;

    assign frm_cnt_d = latch ? frm_cnt_q + 8'd1 : frm_cnt_q;

    always_ff @(posedge clk or negedge erst) begin
        if (!erst) begin
            frm_cnt_q <= '0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
        end
    end

    assign frm_cnt = frm_cnt_q;
`endif

    assign frm_start = frm_start_q;
    assign capt_act  = (state_q == CAPT);
    assign res_a     = res_q.a;
    assign res_b     = res_q.b;
    assign res_c     = res_q.c;
    assign res_valid = res_valid_q;
    assign ovr       = ovr_q;

endmodule
